// File: rtl/dmem_access_ctrl_pkg.sv
// Shared size codes, FSM states and alignment rule for the data-memory access controller.
// Pure declarations; no timing or flow control of its own.
package dmem_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_MRG,
        S_WR
    } state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return ((size == SZ_HALF) && a[0]) || ((size == SZ_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Requester ports, memory-array port and status of the access controller.
// Requests are held until Ack; memory read data follows MemRe by one cycle.
interface dmem_access_ctrl_if #(
    parameter int WORDS = 1024
);
    logic                     Req0, Req1;
    logic                     We0, We1;
    logic [1:0]               Size0, Size1;
    logic [31:0]              Addr0, Addr1;
    logic [31:0]              WData0, WData1;
    logic [31:0]              RData0, RData1;
    logic                     Ack0, Ack1;
    logic                     Err0, Err1;
    logic [$clog2(WORDS)-1:0] MemAddr;
    logic [31:0]              MemWData;
    logic                     MemWe, MemRe;
    logic [31:0]              MemRData;
    logic                     Busy;

    modport slave (
        input  Req0, Req1, We0, We1, Size0, Size1, Addr0, Addr1, WData0, WData1, MemRData,
        output RData0, RData1, Ack0, Ack1, Err0, Err1, MemAddr, MemWData, MemWe, MemRe, Busy
    );

    modport master (
        output Req0, Req1, We0, We1, Size0, Size1, Addr0, Addr1, WData0, WData1, MemRData,
        input  RData0, RData1, Ack0, Ack1, Err0, Err1, MemAddr, MemWData, MemWe, MemRe, Busy
    );

endinterface

// File: rtl/dmem_access_ctrl_lane_unit.sv
// Byte/half lane extraction with sign extension and sub-word store merge; combinational, 0 cycles.
// No flow control: outputs follow inputs.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] Word,
    input  logic [1:0]  Addr,
    input  logic [1:0]  Size,
    input  logic [31:0] WData,
    output logic [31:0] LdVal,
    output logic [31:0] StWord
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = Word[{Addr, 3'b000} +: 8];
        half_lane = Word[{Addr[1], 4'b0000} +: 16];
        LdVal     = Word;
        StWord    = WData;
        case (Size)
            SZ_BYTE: begin
                LdVal  = {{24{byte_lane[7]}}, byte_lane};
                StWord = Word;
                StWord[{Addr, 3'b000} +: 8] = WData[7:0];
            end
            SZ_HALF: begin
                LdVal  = {{16{half_lane[15]}}, half_lane};
                StWord = Word;
                StWord[{Addr[1], 4'b0000} +: 16] = WData[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Round-robin shared data-memory sequencer; word store 2, load/sub-word store 3, misaligned/no-op 1 cycle to Ack.
// Requests wait (held by requester) while Busy; one access in flight at a time.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int WORDS = 1024
) (
    input logic               Clk,
    input logic               Rst_n,
    dmem_access_ctrl_if.slave bus
);

    localparam int AW = $clog2(WORDS);

    state_t          state_q, state_d;
    logic            last_q;
    logic            lat_port, lat_we;
    logic [1:0]      lat_size;
    logic [AW+1:0]   lat_addr;
    logic [31:0]     lat_wdata;
    logic [1:0]      ack_q, err_q, ack_d, err_d;
    logic [31:0]     rdata0_q, rdata1_q;

    logic [1:0]      elig;
    logic            gnt_vld, gnt_port;
    logic            g_we;
    logic [1:0]      g_size;
    logic [AW+1:0]   g_addr;
    logic [31:0]     g_wdata;
    logic            ld_upd, mem_re, mem_we;
    logic [31:0]     mem_wdata, ld_val, st_word;
    logic            unused_addr_hi;

    assign unused_addr_hi = ^{bus.Addr0[31:AW+2], bus.Addr1[31:AW+2]};

    dmem_lane_unit u_lane (
        .Word   (bus.MemRData),
        .Addr   (lat_addr[1:0]),
        .Size   (lat_size),
        .WData  (lat_wdata),
        .LdVal  (ld_val),
        .StWord (st_word)
    );

    always_comb begin
        state_d   = state_q;
        ack_d     = '0;
        err_d     = '0;
        ld_upd    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        gnt_vld   = 1'b0;
        // A port is masked in its own Ack cycle so a still-high Req is not re-granted.
        elig      = {bus.Req1 & ~ack_q[1], bus.Req0 & ~ack_q[0]};
        gnt_port  = (elig == 2'b11) ? ~last_q : elig[1];
        g_we      = gnt_port ? bus.We1 : bus.We0;
        g_size    = gnt_port ? bus.Size1 : bus.Size0;
        g_addr    = gnt_port ? bus.Addr1[AW+1:0] : bus.Addr0[AW+1:0];
        g_wdata   = gnt_port ? bus.WData1 : bus.WData0;
        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    gnt_vld = 1'b1;
                    if (misaligned(g_size, g_addr[1:0]) || (g_size == SZ_NONE)) begin
                        ack_d[gnt_port] = 1'b1;
                        err_d[gnt_port] = misaligned(g_size, g_addr[1:0]);
                    end else if (g_we && (g_size == SZ_WORD)) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                mem_re  = 1'b1;
                state_d = S_MRG;
            end
            S_MRG: begin
                ack_d[lat_port] = 1'b1;
                if (lat_we) begin
                    mem_we    = 1'b1;
                    mem_wdata = st_word;
                end else begin
                    ld_upd = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_WR: begin
                mem_we          = 1'b1;
                mem_wdata       = lat_wdata;
                ack_d[lat_port] = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_size  <= SZ_NONE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            if (gnt_vld) begin
                last_q    <= gnt_port;
                lat_port  <= gnt_port;
                lat_we    <= g_we;
                lat_size  <= g_size;
                lat_addr  <= g_addr;
                lat_wdata <= g_wdata;
            end
            if (ld_upd && !lat_port) rdata0_q <= ld_val;
            if (ld_upd && lat_port)  rdata1_q <= ld_val;
        end
    end

    assign bus.MemAddr  = lat_addr[AW+1:2];
    assign bus.MemRe    = mem_re;
    assign bus.MemWe    = mem_we;
    assign bus.MemWData = mem_wdata;
    assign bus.Ack0     = ack_q[0];
    assign bus.Ack1     = ack_q[1];
    assign bus.Err0     = err_q[0];
    assign bus.Err1     = err_q[1];
    assign bus.RData0   = rdata0_q;
    assign bus.RData1   = rdata1_q;
    assign bus.Busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: memory array model plus arithmetic reference for lanes, latencies and arbitration.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    dmem_access_ctrl_if #(.WORDS(1024)) bus ();
    dmem_access_ctrl #(.WORDS(1024)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];
    logic [31:0] exp_rd [2];
    logic [9:0]  last_re_addr;
    int          checks = 0;
    int          errors = 0;

    // Word-organised memory: writes at the edge, read data one cycle after MemRe.
    always @(posedge Clk) begin
        if (bus.MemWe) mem[bus.MemAddr] <= bus.MemWData;
        if (bus.MemRe) bus.MemRData <= mem[bus.MemAddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic is_misal(input logic [1:0] sz, input logic [31:0] a);
        return ((sz == SZ_HALF) && (a % 2 == 1)) || ((sz == SZ_WORD) && (a % 4 != 0));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] v;
        int sh;
        v = w;
        if (sz == SZ_BYTE) begin
            sh = 8 * int'(a % 4);
            v = (w >> sh) & 32'hFF;
            if (v >= 128) v = v | 32'hFFFF_FF00;
        end else if (sz == SZ_HALF) begin
            sh = 16 * int'((a / 2) % 2);
            v = (w >> sh) & 32'hFFFF;
            if (v >= 32768) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] m;
        int sh;
        if (sz == SZ_BYTE) begin
            sh = 8 * int'(a % 4);
            m = 32'hFF << sh;
            return (w & ~m) | ((d & 32'hFF) << sh);
        end
        if (sz == SZ_HALF) begin
            sh = 16 * int'((a / 2) % 2);
            m = 32'hFFFF << sh;
            return (w & ~m) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    task automatic set_port(input int p, input logic req, input logic we, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
        if (p == 0) begin
            bus.Req0 = req; bus.We0 = we; bus.Size0 = sz; bus.Addr0 = a; bus.WData0 = wd;
        end else begin
            bus.Req1 = req; bus.We1 = we; bus.Size1 = sz; bus.Addr1 = a; bus.WData1 = wd;
        end
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_busy"},   32'(bus.Busy),  '0);
        chk({pfx, "_ack0"},   32'(bus.Ack0),  '0);
        chk({pfx, "_ack1"},   32'(bus.Ack1),  '0);
        chk({pfx, "_err0"},   32'(bus.Err0),  '0);
        chk({pfx, "_err1"},   32'(bus.Err1),  '0);
        chk({pfx, "_rdata0"}, bus.RData0,     '0);
        chk({pfx, "_rdata1"}, bus.RData1,     '0);
        chk({pfx, "_memaddr"},32'(bus.MemAddr),'0);
        chk({pfx, "_memwe"},  32'(bus.MemWe), '0);
        chk({pfx, "_memre"},  32'(bus.MemRe), '0);
        chk({pfx, "_memwdat"},bus.MemWData,   '0);
    endtask

    // One access on port p, started in an IDLE cycle; checks timing, strobes, data and memory.
    task automatic do_access(input int p, input logic we, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
        int cyc, re_n, we_n, re_c, we_c, exp_lat, exp_re_c, exp_we_c;
        logic got, bad, noop, err_o;
        logic [31:0] rd_own, rd_oth, we_dat, expw;
        logic [9:0] wi, we_a;
        wi       = 10'(a >> 2);
        bad      = is_misal(sz, a);
        noop     = (sz == SZ_NONE);
        exp_lat  = (bad || noop) ? 1 : ((we && sz == SZ_WORD) ? 2 : 3);
        exp_re_c = (bad || noop || (we && sz == SZ_WORD)) ? -1 : 1;
        exp_we_c = (bad || noop || !we) ? -1 : ((sz == SZ_WORD) ? 1 : 2);
        expw     = ref_store(shadow[wi], sz, a, wd);
        set_port(p, 1'b1, we, sz, a, wd);
        cyc = 0; got = 1'b0; re_n = 0; we_n = 0; re_c = -1; we_c = -1;
        we_dat = '0; we_a = '0; err_o = 1'b0; rd_own = '0; rd_oth = '0;
        while (!got && cyc < 20) begin
            @(negedge Clk);
            cyc++;
            if (bus.MemRe) begin re_n++; re_c = cyc; last_re_addr = bus.MemAddr; end
            if (bus.MemWe) begin we_n++; we_c = cyc; we_dat = bus.MemWData; we_a = bus.MemAddr; end
            got = (p == 0) ? bus.Ack0 : bus.Ack1;
            if (got) begin
                err_o  = (p == 0) ? bus.Err0 : bus.Err1;
                rd_own = (p == 0) ? bus.RData0 : bus.RData1;
                rd_oth = (p == 0) ? bus.RData1 : bus.RData0;
            end
        end
        set_port(p, 1'b0, 1'b0, SZ_NONE, '0, '0);
        chk("ack_seen",    32'(got), 32'd1);
        chk("ack_latency", cyc, exp_lat);
        chk("err",         32'(err_o), 32'(bad));
        chk("memre_count", re_n, (exp_re_c < 0) ? 0 : 1);
        chk("memre_cycle", re_c, exp_re_c);
        chk("memwe_count", we_n, (exp_we_c < 0) ? 0 : 1);
        chk("memwe_cycle", we_c, exp_we_c);
        if (exp_re_c > 0) chk("memre_addr", 32'(last_re_addr), 32'(wi));
        if (exp_we_c > 0) begin
            chk("memwe_addr", 32'(we_a), 32'(wi));
            chk("memwe_data", we_dat, expw);
            shadow[wi] = expw;
        end
        if (!we && !bad && !noop) exp_rd[p] = ref_load(shadow[wi], sz, a);
        chk("rdata_own",   rd_own, exp_rd[p]);
        chk("rdata_other", rd_oth, exp_rd[1-p]);
        @(negedge Clk);
        chk("mem_word", mem[wi], shadow[wi]);
    endtask

    initial begin
        logic [31:0] v;
        set_port(0, 1'b0, 1'b0, SZ_NONE, '0, '0);
        set_port(1, 1'b0, 1'b0, SZ_NONE, '0, '0);
        last_re_addr = '0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            mem[i] <= v;
            shadow[i] = v;
        end

        repeat (3) @(negedge Clk);
        chk_quiet("in_reset");
        Rst_n = 1'b1;
        @(negedge Clk);
        chk_quiet("after_reset");

        // Tie straight after reset: port 0 first, then strict alternation while both stay held.
        set_port(0, 1'b1, 1'b1, SZ_WORD, 32'h40, 32'hA5A5_0001);
        set_port(1, 1'b1, 1'b1, SZ_WORD, 32'h80, 32'h5A5A_0002);
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            chk("tie_ack0",  32'(bus.Ack0),  32'(c % 4 == 2));
            chk("tie_ack1",  32'(bus.Ack1),  32'(c % 4 == 0));
            chk("tie_memwe", 32'(bus.MemWe), 32'(c % 2 == 1));
            if (c == 12) begin
                set_port(0, 1'b0, 1'b0, SZ_NONE, '0, '0);
                set_port(1, 1'b0, 1'b0, SZ_NONE, '0, '0);
            end
        end
        @(negedge Clk);
        shadow[16] = 32'hA5A5_0001;
        shadow[32] = 32'h5A5A_0002;
        chk("tie_mem16", mem[16], shadow[16]);
        chk("tie_mem32", mem[32], shadow[32]);

        mem[5] <= 32'h80FF_7F01;
        shadow[5] = 32'h80FF_7F01;
        do_access(0, 1'b0, SZ_BYTE, 32'h15, '0);
        chk("lb_0x15", bus.RData0, 32'h0000_007F);
        do_access(0, 1'b0, SZ_BYTE, 32'h16, '0);
        chk("lb_0x16", bus.RData0, 32'hFFFF_FFFF);
        do_access(0, 1'b0, SZ_HALF, 32'h16, '0);
        chk("lh_0x16", bus.RData0, 32'hFFFF_80FF);

        mem[5] <= 32'h1122_3344;
        shadow[5] = 32'h1122_3344;
        do_access(1, 1'b1, SZ_BYTE, 32'h16, 32'h0000_00AB);
        chk("sb_0x16_mem", mem[5], 32'h11AB_3344);

        do_access(0, 1'b0, SZ_WORD, 32'h102, '0);
        do_access(1, 1'b1, SZ_HALF, 32'h7, 32'h1234);
        do_access(0, 1'b1, SZ_NONE, 32'h8, 32'hFFFF_FFFF);
        do_access(1, 1'b0, SZ_WORD, 32'h1000_0010, '0);
        chk("wrap_memaddr", 32'(last_re_addr), 32'd4);
        do_access(0, 1'b1, SZ_WORD, 32'h0C, 32'hDEAD_BEEF);

        // Reset in the merge cycle of a byte store must abandon it without a write or Ack.
        mem[5] <= 32'h1122_3344;
        shadow[5] = 32'h1122_3344;
        set_port(1, 1'b1, 1'b1, SZ_BYTE, 32'h16, 32'h0000_00CD);
        @(negedge Clk);
        chk("rst_mrg_memre", 32'(bus.MemRe), 32'd1);
        @(posedge Clk);
        #1;
        Rst_n = 1'b0;
        #1;
        chk("rst_mrg_we_drop", 32'(bus.MemWe), '0);
        set_port(1, 1'b0, 1'b0, SZ_NONE, '0, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            chk("rst_mrg_no_ack", 32'(bus.Ack1),  '0);
            chk("rst_mrg_no_we",  32'(bus.MemWe), '0);
        end
        Rst_n = 1'b1;
        @(negedge Clk);
        chk_quiet("rst_mrg_release");
        chk("rst_mrg_mem", mem[5], 32'h1122_3344);
        exp_rd[0] = '0;
        exp_rd[1] = '0;

        for (int n = 0; n < 60; n++) begin
            do_access(int'($urandom_range(1, 0)), 1'($urandom), 2'($urandom),
                      $urandom & 32'hFFFF_F03F, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
